// File: rtl/rv_pkg.sv
// Shared constants and types for the RV32I front end.
package rv_pkg;

    localparam int          PC_WIDTH   = 32;
    localparam int          INST_WIDTH = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: capture loads a new instruction, bubble clears
// valid/inst but keeps the pc fields, otherwise everything holds.
module ifid_reg
    import rv_pkg::*;
#(
    parameter int                    PC_WIDTH   = rv_pkg::PC_WIDTH,
    parameter int                    INST_WIDTH = rv_pkg::INST_WIDTH,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(rv_pkg::NOP_INST)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_capture,
    input  logic                  i_bubble,
    input  logic [PC_WIDTH-1:0]   i_pc,
    input  logic [PC_WIDTH-1:0]   i_pc4,
    input  logic [INST_WIDTH-1:0] i_inst,
    output logic                  o_valid,
    output logic [PC_WIDTH-1:0]   o_pc,
    output logic [PC_WIDTH-1:0]   o_pc4,
    output logic [INST_WIDTH-1:0] o_inst
);

    logic                  r_valid;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_pc4;
    logic [INST_WIDTH-1:0] r_inst;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_pc4   <= '0;
            r_inst  <= NOP_INST;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_inst  <= NOP_INST;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;
    assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, fetch FSM and accepted-instruction
// counter in front of the IF/ID register.
//   state | meaning
//   BOOT  | first cycle out of reset, no capture
//   RUN   | normal fetch with redirect/flush/stall
//   ERR   | misaligned redirect seen, fetch frozen until reset
module fetch_stage
    import rv_pkg::*;
#(
    parameter int                    PC_WIDTH   = rv_pkg::PC_WIDTH,
    parameter int                    INST_WIDTH = rv_pkg::INST_WIDTH,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = PC_WIDTH'(rv_pkg::RESET_PC),
    parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(rv_pkg::NOP_INST)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [PC_WIDTH-1:0]   imem_pc,
    input  logic [INST_WIDTH-1:0] imem_inst,
    output logic                  ifid_valid,
    output logic [PC_WIDTH-1:0]   ifid_pc,
    output logic [PC_WIDTH-1:0]   ifid_pc4,
    output logic [INST_WIDTH-1:0] ifid_inst,
    output logic                  misalign_err,
    output logic [31:0]           fetch_count
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_nxt;
    logic [PC_WIDTH-1:0]   w_pc_plus4;
    logic                  w_capture;
    logic                  w_bubble;
    logic                  w_err_set;
    logic                  r_misalign_err;
    logic [31:0]           r_fetch_count;

    assign w_pc_plus4 = r_pc + PC_WIDTH'(4);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_capture   = 1'b0;
        w_bubble    = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            FETCH_BOOT: w_state_nxt = FETCH_RUN;
            FETCH_RUN: begin
                if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                    w_state_nxt = FETCH_ERR;
                    w_err_set   = 1'b1;
                    w_bubble    = 1'b1;
                end else if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    w_bubble = 1'b1;
                end else if (flush) begin
                    w_bubble = 1'b1;
                    if (!stall) w_pc_nxt = w_pc_plus4;
                end else if (!stall) begin
                    w_capture = 1'b1;
                    w_pc_nxt  = w_pc_plus4;
                end
            end
            FETCH_ERR: w_bubble = 1'b1;
            default:   w_state_nxt = FETCH_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= FETCH_BOOT;
            r_pc           <= RESET_PC;
            r_misalign_err <= 1'b0;
            r_fetch_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_err_set) r_misalign_err <= 1'b1;
            if (w_capture && (r_fetch_count != 32'hFFFF_FFFF))
                r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    ifid_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .NOP_INST   (NOP_INST)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_capture),
        .i_bubble  (w_bubble),
        .i_pc      (r_pc),
        .i_pc4     (w_pc_plus4),
        .i_inst    (imem_inst),
        .o_valid   (ifid_valid),
        .o_pc      (ifid_pc),
        .o_pc4     (ifid_pc4),
        .o_inst    (ifid_inst)
    );

    assign imem_pc      = r_pc;
    assign misalign_err = r_misalign_err;
    assign fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random
// traffic, compared against a cycle-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int M_BOOT = 0, M_RUN = 1, M_ERR = 2;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, redirect_valid;
    logic [31:0] redirect_pc, imem_pc, imem_inst;
    logic        ifid_valid, misalign_err;
    logic [31:0] ifid_pc, ifid_pc4, ifid_inst, fetch_count;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    int          m_mode;
    logic [31:0] m_pc, m_ipc, m_ipc4, m_inst, m_cnt;
    logic        m_valid, m_err;

    always #5 clk = ~clk;

    assign imem_inst = 32'h1000_0000 | imem_pc;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .ifid_valid     (ifid_valid),
        .ifid_pc        (ifid_pc),
        .ifid_pc4       (ifid_pc4),
        .ifid_inst      (ifid_inst),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input logic rst, input logic st, input logic fl,
                                       input logic rv, input logic [31:0] rpc);
        if (!rst) begin
            m_mode = M_BOOT; m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0;
            m_ipc4 = 32'h0;  m_inst = NOP; m_err = 1'b0;   m_cnt = 32'h0;
        end else if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_ERR) begin
            m_valid = 1'b0; m_inst = NOP;
        end else if (rv && (rpc % 4 != 0)) begin
            m_mode = M_ERR; m_err = 1'b1; m_valid = 1'b0; m_inst = NOP;
        end else if (rv) begin
            m_pc = rpc; m_valid = 1'b0; m_inst = NOP;
        end else if (fl) begin
            m_valid = 1'b0; m_inst = NOP;
            if (!st) m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_inst = 32'h1000_0000 | m_pc;
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    endfunction

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic cyc(input logic rst, input logic st, input logic fl,
                       input logic rv, input logic [31:0] rpc);
        rst_n = rst; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
        model_step(rst, st, fl, rv, rpc);
        @(posedge clk);
        #1;
        check("imem_pc",      imem_pc,             m_pc);
        check("ifid_valid",   {31'b0, ifid_valid}, {31'b0, m_valid});
        check("ifid_inst",    ifid_inst,           m_inst);
        check("ifid_pc",      ifid_pc,             m_ipc);
        check("ifid_pc4",     ifid_pc4,            m_ipc4);
        check("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
        check("fetch_count",  fetch_count,         m_cnt);
    endtask

    initial begin
        logic st, fl, rv, rs;
        logic [31:0] rpc;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        m_mode = M_BOOT; m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_inst = NOP;
        m_valid = 0; m_err = 0; m_cnt = 0;
        #2;

        // reset, boot, three captures
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 32'h104);
        check("rst_inst", ifid_inst, 32'h0000_0013);
        cyc(1, 0, 0, 0, 0);
        check("boot_valid", {31'b0, ifid_valid}, 32'd0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("cap3_pc", ifid_pc, 32'd8);
        check("cap3_pc4", ifid_pc4, 32'd12);
        check("cap3_cnt", fetch_count, 32'd3);

        // stall two cycles, then release
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("stall_pc", imem_pc, 32'd12);
        cyc(1, 0, 0, 0, 0);
        check("post_stall", ifid_pc, 32'd12);

        // redirect beats stall
        cyc(1, 1, 0, 1, 32'h100);
        check("redir_pc", imem_pc, 32'h100);
        cyc(1, 0, 0, 0, 0);
        check("redir_cap", ifid_pc, 32'h100);

        // flush alone
        cyc(1, 0, 1, 0, 0);
        check("flush_inst", ifid_inst, NOP);
        cyc(1, 0, 0, 0, 0);

        // misaligned redirect, stay frozen despite stall/flush toggling
        cyc(1, 0, 0, 1, 32'h102);
        for (int i = 0; i < 10; i++) cyc(1, i[0], i[1], 0, 0);
        check("err_sticky", {31'b0, misalign_err}, 32'd1);
        cyc(0, 0, 0, 0, 0);
        check("err_clr", {31'b0, misalign_err}, 32'd0);

        // wrap at top of address space
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0);
        check("wrap_pc4", ifid_pc4, 32'h0);
        check("wrap_imem", imem_pc, 32'h0);
        cyc(1, 0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(0, 63) != 0);
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            cyc(rs, st, fl, rv, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
